// File: rtl/data_latch_sequencer.sv
// Sequencer for memory reads through the input data latch: address/read strobe, ready wait,
// sample/transfer strobes, then one bus enable. Also handles two-byte operand fetch and timeout.
module data_latch_sequencer #(
  parameter int unsigned TIMEOUT      = 8,
  parameter int unsigned DRIVE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  req_dest,
  input  logic [15:0] req_addr,
  input  logic        mem_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        dl_clk_2,
  output logic        dl_clk_1,
  output logic        enable_db,
  output logic        enable_adl,
  output logic        enable_adh,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] WaitLast  = 8'(TIMEOUT - 1);
  localparam logic [1:0] DriveLast = 2'(DRIVE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StXfer,
    StDrive,
    StAbort
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  dest_q, dest_d;
  logic        byte_q, byte_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  drive_cnt_q, drive_cnt_d;

  logic        drive_last;
  logic        first_of_pair;

  assign drive_last    = (drive_cnt_q == DriveLast);
  // Low byte of a two-byte fetch: another read follows instead of done.
  assign first_of_pair = (dest_q == 2'b11) && !byte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= 16'h0000;
      dest_q      <= 2'b00;
      byte_q      <= 1'b0;
      wait_cnt_q  <= 8'd0;
      drive_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dest_q      <= dest_d;
      byte_q      <= byte_d;
      wait_cnt_q  <= wait_cnt_d;
      drive_cnt_q <= drive_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dest_d      = dest_q;
    byte_d      = byte_q;
    wait_cnt_d  = wait_cnt_q;
    drive_cnt_d = drive_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = req_addr;
          dest_d  = req_dest;
          byte_d  = 1'b0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        wait_cnt_d = 8'd0;
        state_d    = StWait;
      end
      StWait: begin
        if (mem_rdy) begin
          state_d = StXfer;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StAbort;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StXfer: begin
        drive_cnt_d = 2'd0;
        state_d     = StDrive;
      end
      StDrive: begin
        if (drive_last) begin
          if (first_of_pair) begin
            byte_d  = 1'b1;
            addr_d  = addr_q + 16'd1;
            state_d = StAddr;
          end else begin
            state_d = StIdle;
          end
        end else begin
          drive_cnt_d = drive_cnt_q + 2'd1;
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_rd     = (state_q == StAddr) || (state_q == StWait);
    mem_addr   = mem_rd ? addr_q : 16'h0000;
    // Sample strobe follows mem_rdy in the same cycle.
    dl_clk_2   = (state_q == StWait) && mem_rdy;
    dl_clk_1   = (state_q == StXfer);
    enable_db  = 1'b0;
    enable_adl = 1'b0;
    enable_adh = 1'b0;
    if (state_q == StDrive) begin
      unique case (dest_q)
        2'b00:   enable_db  = 1'b1;
        2'b01:   enable_adl = 1'b1;
        2'b10:   enable_adh = 1'b1;
        default: begin
          enable_adl = !byte_q;
          enable_adh = byte_q;
        end
      endcase
    end
    busy = (state_q != StIdle);
    done = (state_q == StDrive) && drive_last && !first_of_pair;
    err  = (state_q == StAbort);
  end

endmodule

// File: tb/tb_data_latch_sequencer.sv
// Bench for data_latch_sequencer: builds an expected per-cycle trace from the transfer rules,
// then replays the stimulus and compares every output each cycle.
module tb_data_latch_sequencer;

  localparam int unsigned Timeout     = 8;
  localparam int unsigned DriveCycles = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic [1:0]  req_dest;
  logic [15:0] req_addr;
  logic        mem_rdy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        dl_clk_2;
  logic        dl_clk_1;
  logic        enable_db;
  logic        enable_adl;
  logic        enable_adh;
  logic        busy;
  logic        done;
  logic        err;

  data_latch_sequencer #(
    .TIMEOUT     (Timeout),
    .DRIVE_CYCLES(DriveCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_dest  (req_dest),
    .req_addr  (req_addr),
    .mem_rdy   (mem_rdy),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .dl_clk_2  (dl_clk_2),
    .dl_clk_1  (dl_clk_1),
    .enable_db (enable_db),
    .enable_adl(enable_adl),
    .enable_adh(enable_adh),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [1:0]  dest;
    logic [15:0] addr;
    logic        rdy;
    logic        chk;
    logic [24:0] exp;
  } step_t;

  step_t plan[$];
  int    errors = 0;
  int    checks = 0;
  int    done_expected = 0;
  int    done_seen = 0;

  // {mem_addr, mem_rd, dl_clk_2, dl_clk_1, enable_db, enable_adl, enable_adh, busy, done, err}
  function automatic logic [24:0] outv(logic [15:0] a, logic rd, logic c2, logic c1,
                                       logic [2:0] en, logic bsy, logic dn, logic er);
    return {a, rd, c2, c1, en, bsy, dn, er};
  endfunction

  task automatic add(logic rst, logic rq, logic rdy, logic [24:0] e, logic chk);
    step_t s;
    s.rst  = rst;
    s.req  = rq;
    s.dest = 2'($urandom);
    s.addr = 16'($urandom);
    s.rdy  = rdy;
    s.chk  = chk;
    s.exp  = e;
    plan.push_back(s);
  endtask

  task automatic idle(int n, logic rst);
    for (int i = 0; i < n; i++) add(rst, 1'b0, 1'($urandom), '0, 1'b1);
  endtask

  // One requested transfer. stall[b] = WAIT cycles without ready for byte b (>= Timeout aborts).
  // cut: reset during the first DRIVE cycle of the first byte.
  task automatic xfer(logic [1:0] dest, logic [15:0] addr, int stall0, int stall1, bit cut);
    step_t      s;
    logic [15:0] a;
    int          nbytes;
    int          st;
    int          sel;
    logic [2:0]  en;
    bit          last;
    s.rst  = 1'b0;
    s.req  = 1'b1;
    s.dest = dest;
    s.addr = addr;
    s.rdy  = 1'($urandom);
    s.chk  = 1'b1;
    s.exp  = '0;
    plan.push_back(s);
    a      = addr;
    nbytes = (dest == 2'b11) ? 2 : 1;
    for (int b = 0; b < nbytes; b++) begin
      st  = (b == 0) ? stall0 : stall1;
      sel = (dest == 2'b11) ? b + 1 : int'(dest);
      en  = {sel == 0, sel == 1, sel == 2};
      add(1'b0, 1'($urandom), 1'($urandom), outv(a, 1, 0, 0, 3'b000, 1, 0, 0), 1'b1);
      if (st >= int'(Timeout)) begin
        for (int i = 0; i < int'(Timeout); i++)
          add(1'b0, 1'($urandom), 1'b0, outv(a, 1, 0, 0, 3'b000, 1, 0, 0), 1'b1);
        add(1'b0, 1'($urandom), 1'($urandom), outv(16'h0, 0, 0, 0, 3'b000, 1, 0, 1), 1'b1);
        return;
      end
      for (int i = 0; i < st; i++)
        add(1'b0, 1'($urandom), 1'b0, outv(a, 1, 0, 0, 3'b000, 1, 0, 0), 1'b1);
      add(1'b0, 1'($urandom), 1'b1, outv(a, 1, 1, 0, 3'b000, 1, 0, 0), 1'b1);
      add(1'b0, 1'($urandom), 1'($urandom), outv(16'h0, 0, 0, 1, 3'b000, 1, 0, 0), 1'b1);
      for (int d = 0; d < int'(DriveCycles); d++) begin
        if (cut) begin
          add(1'b1, 1'($urandom), 1'($urandom), outv(16'h0, 0, 0, 0, en, 1, 0, 0), 1'b1);
          return;
        end
        last = (d == int'(DriveCycles) - 1) && (b == nbytes - 1);
        if (last) done_expected++;
        add(1'b0, 1'($urandom), 1'($urandom), outv(16'h0, 0, 0, 0, en, 1, last, 0), 1'b1);
      end
      a = a + 16'd1;
    end
  endtask

  always @(posedge clk) if (done === 1'b1) done_seen++;

  initial begin
    logic [24:0] obs;
    int          stall0;
    int          stall1;
    reset    = 1'b1;
    req      = 1'b0;
    req_dest = 2'b00;
    req_addr = 16'h0000;
    mem_rdy  = 1'b0;

    add(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    xfer(2'b00, 16'h1234, 0, 0, 0);
    idle(1, 1'b0);
    idle(2, 1'b1);
    idle(1, 1'b0);
    xfer(2'b00, 16'h1234, 0, 0, 0);
    xfer(2'b01, 16'($urandom), 3, 0, 0);
    xfer(2'b11, 16'hFFFF, 0, 0, 0);
    idle(1, 1'b0);
    xfer(2'b10, 16'($urandom), int'(Timeout) - 1, 0, 0);
    xfer(2'b00, 16'($urandom), 100, 0, 0);
    idle(2, 1'b0);
    xfer(2'b11, 16'h00FF, 1, 20, 0);
    xfer(2'b11, 16'hABCD, 0, 0, 1);
    idle(4, 1'b0);
    for (int t = 0; t < 40; t++) begin
      idle(int'($urandom_range(0, 2)), 1'b0);
      stall0 = ($urandom_range(0, 7) == 0) ? int'(Timeout) + int'($urandom_range(0, 2))
                                           : int'($urandom_range(0, 4));
      stall1 = ($urandom_range(0, 7) == 0) ? int'(Timeout) : int'($urandom_range(0, 4));
      xfer(2'($urandom), 16'($urandom), stall0, stall1, 0);
    end
    idle(3, 1'b0);

    foreach (plan[i]) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      reset    = plan[i].rst;
      req      = plan[i].req;
      req_dest = plan[i].dest;
      req_addr = plan[i].addr;
      mem_rdy  = plan[i].rdy;
      @(negedge clk);
      if (plan[i].chk) begin
        obs = {mem_addr, mem_rd, dl_clk_2, dl_clk_1, enable_db, enable_adl, enable_adh,
               busy, done, err};
        checks++;
        assert (obs === plan[i].exp)
        else begin
          errors++;
          $error("FAIL cycle_%0d: observed addr=%h rd/c2/c1/db/adl/adh/busy/done/err=%b required addr=%h %b",
                 i, obs[24:9], obs[8:0], plan[i].exp[24:9], plan[i].exp[8:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert (done_seen === done_expected)
    else begin
      errors++;
      $error("FAIL done_count: observed %0d required %0d", done_seen, done_expected);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
